cyber_opponent_core: RTL and testbench

- Computer-opponent datapath for the tug-of-war game. A free-running maximal-length LFSR generates a pseudo-random value every clock.
- An unsigned magnitude comparator fires a "push" when the player-set difficulty threshold exceeds the random value.
- An independent BCD-to-7-segment decoder drives a HEX digit for the win counters.
- Sits between the board switches/clock divider and the game FSM (push feeds the opponent's input conditioner).

---
 rtl/cyber_opponent_core_if.sv | 36 +++
 rtl/cyber_opponent_core.sv | 80 ++++++++
 tb/tb_cyber_opponent_core.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cyber_opponent_core_if.sv
// Signal bundle between the board/game logic and the computer-opponent core.
//   threshold : difficulty value driven by the switches (comparator operand a)
//   bcd       : digit to show on the HEX display
//   q         : current LFSR state (comparator operand b)
//   lfsr_out  : feedback bit that shifts into q on the next clock
//   push      : opponent push request, threshold > q
//   leds      : active-low segments {g,f,e,d,c,b,a}
// master = the surrounding board/game logic, slave = the core.
interface cyber_opponent_core_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] threshold;
    logic [3:0]       bcd;
    logic [WIDTH-1:0] q;
    logic             lfsr_out;
    logic             push;
    logic [6:0]       leds;

    modport master (
        output threshold,
        output bcd,
        input  q,
        input  lfsr_out,
        input  push,
        input  leds
    );

    modport slave (
        input  threshold,
        input  bcd,
        output q,
        output lfsr_out,
        output push,
        output leds
    );
endinterface

// File: rtl/cyber_opponent_core.sv
// Computer-opponent datapath for the tug-of-war game.
//   - Free-running maximal-length XNOR LFSR; all-zeros is the reset state,
//     all-ones is the unreachable lock-up state.
//   - Unsigned comparator: push = threshold > q.
//   - Independent BCD to 7-segment decoder (active-low, gfedcba).
// Ports:
//   clk   : game clock, all state on rising edge
//   reset : asynchronous, active-low reset (clears the LFSR to 0)
//   bus   : slave side of cyber_opponent_core_if (threshold, bcd in;
//           q, lfsr_out, push, leds out)
// WIDTH must match the interface instance and lie in 3..12.
module cyber_opponent_core #(
    parameter int unsigned WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    cyber_opponent_core_if.slave bus
);

    // XNOR tap positions for each supported width, bit i = tap position i+1.
    function automatic logic [11:0] tap_mask(input int unsigned w);
        case (w)
            3:       tap_mask = 12'b0000_0000_0110;
            4:       tap_mask = 12'b0000_0000_1100;
            5:       tap_mask = 12'b0000_0001_0100;
            6:       tap_mask = 12'b0000_0011_0000;
            7:       tap_mask = 12'b0000_0110_0000;
            8:       tap_mask = 12'b0000_1011_1000;
            9:       tap_mask = 12'b0001_0001_0000;
            10:      tap_mask = 12'b0010_0100_0000;
            11:      tap_mask = 12'b0101_0000_0000;
            12:      tap_mask = 12'b1000_0010_1001;
            default: tap_mask = 12'b0000_0000_0000;
        endcase
    endfunction

    localparam logic [11:0]      TapsAll = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] Taps    = TapsAll[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             feedback;

    // Reduction XNOR over the masked taps; untapped bits contribute zeros.
    always_comb begin
        feedback = ~(^(lfsr_q & Taps));
        lfsr_d   = {lfsr_q[WIDTH-2:0], feedback};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bus.q        = lfsr_q;
    assign bus.lfsr_out = feedback;
    assign bus.push     = (bus.threshold > lfsr_q);

    // Active-low segments, blank for non-decimal codes.
    always_comb begin
        bus.leds = 7'b111_1111;
        case (bus.bcd)
            4'd0:    bus.leds = 7'b100_0000;
            4'd1:    bus.leds = 7'b111_1001;
            4'd2:    bus.leds = 7'b010_0100;
            4'd3:    bus.leds = 7'b011_0000;
            4'd4:    bus.leds = 7'b001_1001;
            4'd5:    bus.leds = 7'b001_0010;
            4'd6:    bus.leds = 7'b000_0010;
            4'd7:    bus.leds = 7'b111_1000;
            4'd8:    bus.leds = 7'b000_0000;
            4'd9:    bus.leds = 7'b001_0000;
            default: bus.leds = 7'b111_1111;
        endcase
    end

endmodule

// File: tb/tb_cyber_opponent_core.sv
module tb_cyber_opponent_core;

    localparam int W    = 10;
    localparam int Mask = (1 << W) - 1;

    logic clk;
    logic reset;

    cyber_opponent_core_if #(.WIDTH(W)) bus ();

    cyber_opponent_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: next state of a 10-bit XNOR LFSR with taps 10 and 7.
    function automatic int lfsr_next(input int m);
        int fb;
        fb = 1 ^ ((m >> 9) & 1) ^ ((m >> 6) & 1);
        return ((m << 1) | fb) & Mask;
    endfunction

    typedef struct {
        int bcd;
        int leds;
    } seg_vec_t;

    typedef struct {
        int thr;
        int push;
    } cmp_vec_t;

    seg_vec_t seg_tab[16];
    cmp_vec_t cmp_tab[5];

    int m;
    int early_zero;
    int saw_ones;

    initial begin
        checks   = 0;
        failures = 0;

        seg_tab[0]  = '{0,  7'b100_0000};
        seg_tab[1]  = '{1,  7'b111_1001};
        seg_tab[2]  = '{2,  7'b010_0100};
        seg_tab[3]  = '{3,  7'b011_0000};
        seg_tab[4]  = '{4,  7'b001_1001};
        seg_tab[5]  = '{5,  7'b001_0010};
        seg_tab[6]  = '{6,  7'b000_0010};
        seg_tab[7]  = '{7,  7'b111_1000};
        seg_tab[8]  = '{8,  7'b000_0000};
        seg_tab[9]  = '{9,  7'b001_0000};
        for (int i = 10; i < 16; i++) seg_tab[i] = '{i, 7'b111_1111};

        // q is held at 0 under reset
        cmp_tab[0] = '{0,    0};
        cmp_tab[1] = '{1,    1};
        cmp_tab[2] = '{73,   1};
        cmp_tab[3] = '{1023, 1};
        cmp_tab[4] = '{2,    1};

        // Reset held for three edges
        reset         = 1'b0;
        bus.threshold = '0;
        bus.bcd       = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_q_hold", int'(bus.q), 0);
        end
        chk("reset_lfsr_out", int'(bus.lfsr_out), lfsr_next(0) & 1);

        for (int i = 0; i < 5; i++) begin
            bus.threshold = cmp_tab[i].thr[W-1:0];
            #1;
            chk($sformatf("reset_push_thr%0d", cmp_tab[i].thr), int'(bus.push), cmp_tab[i].push);
        end

        for (int i = 0; i < 16; i++) begin
            bus.bcd = seg_tab[i].bcd[3:0];
            #1;
            chk($sformatf("seg7_bcd%0d", seg_tab[i].bcd), int'(bus.leds), seg_tab[i].leds);
        end

        // Release and run one full period with random thresholds
        @(negedge clk);
        reset         = 1'b1;
        bus.threshold = 10'd73;
        m             = 0;
        early_zero    = 0;
        saw_ones      = 0;
        for (int e = 1; e <= 1023; e++) begin
            @(posedge clk);
            #1;
            m = lfsr_next(m);
            chk("run_q", int'(bus.q), m);
            chk("run_lfsr_out", int'(bus.lfsr_out), lfsr_next(m) & 1);
            if (e == 1) chk("first_q", int'(bus.q), 1);
            if (e == 2) chk("second_q", int'(bus.q), 3);
            if (e == 3) chk("third_q", int'(bus.q), 7);
            if (e == 7) begin
                chk("edge7_q", int'(bus.q), 127);
                chk("edge7_push", int'(bus.push), 0);
            end
            if (e < 1023 && bus.q == '0) early_zero++;
            if (bus.q == 10'h3FF) saw_ones++;
            if (e > 7) begin
                if (e % 16 == 0) bus.threshold = bus.q;
                else bus.threshold = 10'($urandom_range(0, Mask));
            end
            #1;
            chk("run_push", int'(bus.push), (int'(bus.threshold) > m) ? 1 : 0);
            if (e % 16 == 0) chk("equal_push", int'(bus.push), 0);
        end
        chk("period_wrap_q", int'(bus.q), 0);
        chk("period_early_zero", early_zero, 0);
        chk("period_all_ones", saw_ones, 0);

        // Asynchronous reset between edges, then identical restart
        for (int i = 0; i < 20; i++) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_q", int'(bus.q), 0);
        @(posedge clk);
        #1;
        chk("async_reset_hold", int'(bus.q), 0);
        @(negedge clk);
        reset = 1'b1;
        m     = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            m = lfsr_next(m);
            chk("restart_q", int'(bus.q), m);
            if (i == 0) chk("restart_first", int'(bus.q), 1);
        end

        // Random thresholds with random asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (reset) m = lfsr_next(m);
            else m = 0;
            chk("rand_q", int'(bus.q), m);
            bus.threshold = 10'($urandom_range(0, Mask));
            bus.bcd       = 4'($urandom_range(0, 15));
            #1;
            chk("rand_push", int'(bus.push), (int'(bus.threshold) > m) ? 1 : 0);
            chk("rand_leds", int'(bus.leds), seg_tab[int'(bus.bcd)].leds);
            reset = ($urandom_range(0, 31) != 0);
            if (!reset) m = 0;
            #1;
            chk("rand_async_q", int'(bus.q), m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
